// File: rtl/rat_path_tracker.sv
// Rat-maze path tracker: turns dequeued move codes into a stream of visited (X,Y) cells.
// Out-of-grid moves park the tracker in an error state instead of wrapping.
module rat_path_tracker #(
    parameter int unsigned    N       = 4,
    parameter logic [N-1:0]   START_X = '0,
    parameter logic [N-1:0]   START_Y = '0,
    parameter int unsigned    SCW     = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           begin_i,
    input  logic           path_empty,
    input  logic           dir_valid,
    input  logic [1:0]     dir,
    input  logic           dir_last,
    output logic           dir_ready,
    output logic           pos_valid,
    input  logic           pos_ready,
    output logic [N-1:0]   pos_x,
    output logic [N-1:0]   pos_y,
    output logic           pos_last,
    output logic [SCW-1:0] step_cnt,
    output logic           busy,
    output logic           done,
    output logic           err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EMIT,
        S_WAIT_DIR,
        S_DONE,
        S_ERR
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_x;
    logic [N-1:0]   r_y;
    logic           r_last;
    logic [SCW-1:0] r_cnt;
    logic [N-1:0]   w_x_nxt;
    logic [N-1:0]   w_y_nxt;
    logic           w_oob;
    logic           w_start;
    logic           w_move;

    // Candidate coordinate for the offered move; edges of the grid flag w_oob.
    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        w_oob   = 1'b0;
        unique case (dir)
            2'b00: begin
                if (r_x == '1) w_oob = 1'b1;
                else           w_x_nxt = r_x + N'(1);
            end
            2'b01: begin
                if (r_y == '1) w_oob = 1'b1;
                else           w_y_nxt = r_y + N'(1);
            end
            2'b10: begin
                if (r_x == '0) w_oob = 1'b1;
                else           w_x_nxt = r_x - N'(1);
            end
            default: begin
                if (r_y == '0) w_oob = 1'b1;
                else           w_y_nxt = r_y - N'(1);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_move      = 1'b0;
        pos_valid   = 1'b0;
        dir_ready   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                done = (r_state == S_DONE);
                err  = (r_state == S_ERR);
                if (begin_i) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                pos_valid = 1'b1;
                busy      = 1'b1;
                if (pos_ready) w_state_nxt = r_last ? S_DONE : S_WAIT_DIR;
            end
            S_WAIT_DIR: begin
                dir_ready = 1'b1;
                busy      = 1'b1;
                if (dir_valid) begin
                    if (w_oob) begin
                        w_state_nxt = S_ERR;
                    end else begin
                        w_move      = 1'b1;
                        w_state_nxt = S_EMIT;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x    <= START_X;
            r_y    <= START_Y;
            r_last <= 1'b0;
            r_cnt  <= '0;
        end else if (w_start) begin
            r_x    <= START_X;
            r_y    <= START_Y;
            r_last <= path_empty;
            r_cnt  <= '0;
        end else if (w_move) begin
            r_x    <= w_x_nxt;
            r_y    <= w_y_nxt;
            r_last <= dir_last;
            if (r_cnt != '1) r_cnt <= r_cnt + SCW'(1);
        end
    end

    // pos_last only means something alongside a valid coordinate.
    assign pos_last = r_last && (r_state == S_EMIT);
    assign pos_x    = r_x;
    assign pos_y    = r_y;
    assign step_cnt = r_cnt;

endmodule

// File: tb/tb_rat_path_tracker.sv
// Bench for rat_path_tracker: integer-level path model checked every cycle,
// plus directed tests with literal coordinate streams.
module tb_rat_path_tracker;

    localparam int N    = 4;
    localparam int SCW  = 8;
    localparam int SX   = 0;
    localparam int SY   = 0;
    localparam int MAXC = (1 << N) - 1;
    localparam int CMAX = (1 << SCW) - 1;

    logic           clk;
    logic           rst;
    logic           begin_i;
    logic           path_empty;
    logic           dir_valid;
    logic [1:0]     dir;
    logic           dir_last;
    logic           dir_ready;
    logic           pos_valid;
    logic           pos_ready;
    logic [N-1:0]   pos_x;
    logic [N-1:0]   pos_y;
    logic           pos_last;
    logic [SCW-1:0] step_cnt;
    logic           busy;
    logic           done;
    logic           err;

    rat_path_tracker #(
        .N      (N),
        .START_X(4'd0),
        .START_Y(4'd0),
        .SCW    (SCW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .begin_i   (begin_i),
        .path_empty(path_empty),
        .dir_valid (dir_valid),
        .dir       (dir),
        .dir_last  (dir_last),
        .dir_ready (dir_ready),
        .pos_valid (pos_valid),
        .pos_ready (pos_ready),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .pos_last  (pos_last),
        .step_cnt  (step_cnt),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {P_IDLE, P_SHOW, P_NEED_MOVE, P_FINISHED, P_FAULT} phase_t;
    phase_t mph;
    int     mx, my, mcnt;
    bit     mlast;
    bit     m_init = 1'b0;

    function automatic int step_x(input int x, input logic [1:0] d);
        return (d == 2'd0) ? x + 1 : (d == 2'd2) ? x - 1 : x;
    endfunction

    function automatic int step_y(input int y, input logic [1:0] d);
        return (d == 2'd1) ? y + 1 : (d == 2'd3) ? y - 1 : y;
    endfunction

    function automatic bit in_grid(input int v);
        return (v >= 0) && (v <= MAXC);
    endfunction

    always @(posedge clk) begin
        m_init <= 1'b1;
        if (rst) begin
            mph <= P_IDLE; mx <= SX; my <= SY; mcnt <= 0; mlast <= 1'b0;
        end else begin
            case (mph)
                P_IDLE, P_FINISHED, P_FAULT:
                    if (begin_i) begin
                        mph <= P_SHOW; mx <= SX; my <= SY; mcnt <= 0; mlast <= path_empty;
                    end
                P_SHOW:
                    if (pos_ready) mph <= mlast ? P_FINISHED : P_NEED_MOVE;
                P_NEED_MOVE:
                    if (dir_valid) begin
                        if (in_grid(step_x(mx, dir)) && in_grid(step_y(my, dir))) begin
                            mx    <= step_x(mx, dir);
                            my    <= step_y(my, dir);
                            mlast <= dir_last;
                            mcnt  <= (mcnt < CMAX) ? mcnt + 1 : CMAX;
                            mph   <= P_SHOW;
                        end else begin
                            mph <= P_FAULT;
                        end
                    end
                default: mph <= P_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("pos_valid", pos_valid, mph == P_SHOW);
            chk("pos_last",  pos_last,  (mph == P_SHOW) && mlast);
            chk("dir_ready", dir_ready, mph == P_NEED_MOVE);
            chk("busy",      busy,      (mph == P_SHOW) || (mph == P_NEED_MOVE));
            chk("done",      done,      mph == P_FINISHED);
            chk("err",       err,       mph == P_FAULT);
            chk("pos_x",     pos_x,     mx);
            chk("pos_y",     pos_y,     my);
            chk("step_cnt",  step_cnt,  mcnt);
        end
    end

    // ---------------- stream capture ----------------
    int got[$];
    int n_dir_ready;

    always @(posedge clk) begin
        if (!rst && pos_valid && pos_ready) got.push_back(pos_x * 1000 + pos_y * 10 + pos_last);
        if (dir_ready) n_dir_ready++;
    end

    task automatic check_stream(input string nm, input int exp[$]);
        chk({nm, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) chk(nm, got[i], exp[i]);
    endtask

    // ---------------- stimulus helpers (called at negedge) ----------------
    task automatic start(input logic empty);
        got.delete();
        n_dir_ready = 0;
        begin_i = 1'b1; path_empty = empty;
        @(negedge clk);
        begin_i = 1'b0; path_empty = 1'b0;
    endtask

    task automatic send(input logic [1:0] d, input logic l);
        int k = 0;
        while (!dir_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!dir_ready) begin
            chk("dir_ready_timeout", 0, 1);
            return;
        end
        dir_valid = 1'b1; dir = d; dir_last = l;
        @(negedge clk);
        dir_valid = 1'b0; dir_last = 1'b0;
    endtask

    task automatic wait_end();
        int k = 0;
        while (!(done || err) && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!(done || err)) chk("end_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e[$];
        rst = 1'b1; begin_i = 1'b0; path_empty = 1'b0; dir_valid = 1'b0;
        dir = 2'b00; dir_last = 1'b0; pos_ready = 1'b1;
        n_dir_ready = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pos_x", pos_x, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // T1: simple path
        start(1'b0);
        send(2'd0, 1'b0); send(2'd0, 1'b0); send(2'd1, 1'b1);
        wait_end();
        e = '{0, 1000, 2000, 2011};
        check_stream("T1_stream", e);
        chk("T1_step", step_cnt, 3);
        chk("T1_done", done, 1);

        // T2: empty path from DONE
        start(1'b1);
        wait_end();
        e = '{1};
        check_stream("T2_stream", e);
        chk("T2_done", done, 1);
        chk("T2_dir_ready_cycles", n_dir_ready, 0);

        // T3: off-grid move at origin, then restart from ERR
        start(1'b0);
        send(2'd2, 1'b0);
        @(negedge clk);
        chk("T3_err", err, 1);
        chk("T3_x", pos_x, 0);
        chk("T3_step", step_cnt, 0);
        e = '{0};
        check_stream("T3_stream", e);
        start(1'b0);
        chk("T3_err_cleared", err, 0);
        send(2'd0, 1'b1);
        wait_end();
        e = '{0, 1001};
        check_stream("T3b_stream", e);
        chk("T3b_done", done, 1);

        // T4: walk to right edge, then one more step must fault
        start(1'b0);
        for (int i = 0; i < 15; i++) send(2'd0, 1'b0);
        send(2'd0, 1'b0);
        wait_end();
        chk("T4_err", err, 1);
        chk("T4_x", pos_x, 15);
        chk("T4_step", step_cnt, 15);
        e.delete();
        for (int i = 0; i < 16; i++) e.push_back(i * 1000);
        check_stream("T4_stream", e);

        // T5: backpressure with a pending move and a stray begin_i
        start(1'b0);
        send(2'd0, 1'b0);
        pos_ready = 1'b0; dir_valid = 1'b1; dir = 2'd1;
        for (int i = 0; i < 5; i++) begin
            begin_i = (i == 0);
            @(negedge clk);
            begin_i = 1'b0;
            chk("T5_hold_x", pos_x, 1);
            chk("T5_hold_y", pos_y, 0);
            chk("T5_hold_valid", pos_valid, 1);
            chk("T5_hold_dir_ready", dir_ready, 0);
        end
        dir_valid = 1'b0; pos_ready = 1'b1;
        send(2'd1, 1'b1);
        wait_end();
        e = '{0, 1000, 1011};
        check_stream("T5_stream", e);
        chk("T5_step", step_cnt, 2);

        // T6: reset while waiting for a move
        start(1'b0);
        send(2'd0, 1'b0); send(2'd1, 1'b0);
        @(negedge clk);
        chk("T6_wait", dir_ready, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("T6_busy", busy, 0);
        chk("T6_x", pos_x, 0);
        chk("T6_y", pos_y, 0);
        chk("T6_step", step_cnt, 0);
        chk("T6_valid", pos_valid, 0);
        e = '{0, 1000, 1010};
        check_stream("T6_stream", e);
        @(negedge clk);

        // T7: step counter saturation on a long back-and-forth path
        start(1'b0);
        for (int i = 0; i < 300; i++) send((i % 2) ? 2'd2 : 2'd0, i == 299);
        wait_end();
        chk("T7_step_sat", step_cnt, 255);
        chk("T7_done", done, 1);
        chk("T7_x", pos_x, 0);
        chk("T7_len", got.size(), 301);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
